jtframe_sync_gen: RTL and testbench
===================================

# jtframe_sync_gen

Programmable video timing generator, the transmitter-side counterpart of the sync re-synchroniser. Runs on the system clock gated by a pixel clock enable. Produces horizontal/vertical counters, active-low blanking (LHBL, LVBL) and active-high sync (HS, VS). Sync position can be shifted relative to blanking by signed per-frame offsets. Feeds core video pipelines and downstream sync-conditioning blocks.

## Interface
Parameters:
- HCNTW, 10: horizontal counter width.
- VCNTW, 9: vertical counter width.
- H_TOTAL, 400: pixels per line. Counter runs 0..H_TOTAL-1.
- HB_START, 320: first blanked pixel. Active pixels are 0..HB_START-1.
- HS_START, 336; HS_END, 368: HS asserted for hcnt in [HS_START, HS_END) before offset.
- V_TOTAL, 262: lines per frame.
- VB_START, 224: first blanked line. Active lines are 0..VB_START-1.
- VS_START, 234; VS_END, 237: VS line window before offset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- pxl_cen  in  1  pixel clock enable. All state advances only when high.
- hoffset  in  4  signed HS/VS horizontal shift in pixels, range -8..+7.
- voffset  in  4  signed VS vertical shift in lines, range -8..+7.
- hcnt  out  HCNTW  current pixel index.
- vcnt  out  VCNTW  current line index.
- LHBL  out  1  low during horizontal blank.
- LVBL  out  1  low during vertical blank.
- HS  out  1  horizontal sync.
- VS  out  1  vertical sync.
- field  out  1  current interlace field. Constant 0 unless interlace is compiled in.

## Operation
- Reset values: hcnt=0, vcnt=0, LHBL=1, LVBL=1, HS=0, VS=0, field=0, latched offsets=0. Reset is asynchronous: asserting rst mid-frame forces these values immediately.
- Counting, on each pxl_cen:
  - hcnt increments and wraps from H_TOTAL-1 to 0.
  - On that wrap, vcnt increments. vcnt wraps from last_line to 0, where last_line=V_TOTAL-1 (V_TOTAL in the odd field under interlace).
- Outputs are computed from the next counter values and registered in the same edge, so hcnt, vcnt, LHBL, LVBL, HS and VS always describe the same pixel.
  - LHBL = (hcnt < HB_START).
  - LVBL = (vcnt < VB_START).
- Offset latching: hoffset and voffset are sampled only when the counters wrap to (0,0). Mid-frame changes take effect at the next frame.
- Sign handling: offsets are sign-extended to counter width.
  - hs_s = (HS_START + hoff) mod H_TOTAL; hs_e = (HS_END + hoff) mod H_TOTAL.
  - vs_s = (VS_START + voff) mod V_TOTAL; vs_e = (VS_END + voff) mod V_TOTAL.
  - Modulo is done by a single conditional add/subtract of the total. Offsets are smaller than any total, so one correction suffices.
- HS: set when hcnt==hs_s, cleared when hcnt==hs_e. A window that wraps past H_TOTAL-1 is legal and stays continuous across the line boundary.
- VS: set at pixel hcnt==hs_s of line vs_s, cleared at pixel hcnt==hs_s of line vs_e. VS edges are therefore coincident with HS rising edges.
- If a set and a clear condition coincide (start==end), the output stays 0.
- pxl_cen low: every register holds its value.

## Timing
- One pxl_cen per pixel. Outputs change one clk after the enabled edge; there is no further latency.
- Line period is H_TOTAL enables.
- Frame period is H_TOTAL*V_TOTAL enables. Under interlace it is H_TOTAL*(V_TOTAL+1) in the odd field.
- HS width is HS_END-HS_START pixels. VS width is VS_END-VS_START lines.
- field toggles on the frame wrap, in the same cycle as vcnt returns to 0.

## Configuration
- JTFRAME_SYNC_GEN_INTERLACE_EN defined:
  - field toggles every frame.
  - The odd field (field=1) has V_TOTAL+1 lines.
  - In the odd field, VS edges move to pixel (hs_s + H_TOTAL/2) mod H_TOTAL, i.e. half a line late.
- Not defined: field is tied to 0, every frame has V_TOTAL lines, and VS edges are always at hs_s.

## Test plan
- Reset release with pxl_cen=1 for 400 cycles: hcnt goes 0..399 then 0; vcnt=1 after the wrap; LHBL falls at hcnt=320 and rises at hcnt=0; HS is high for hcnt 336..367.
- Full frame with zero offsets: LVBL low for lines 224..261; VS rises at (line 234, pixel 336) and falls at (line 237, pixel 336); frame length 104800 enables.
- hoffset=-8 (4'b1000) and voffset=+7 applied mid-frame: no change until the next (0,0); the next frame has HS at 328..359 and VS at lines 241..244.
- pxl_cen toggling 1-of-4 plus rst asserted at line 100: counters advance only on enabled cycles; on rst all outputs return to reset values with no clk edge; counting restarts from 0.
- Edge case: HS_START=396, HS_END=4, hoffset=+7 → HS high for pixels 3..10 of the next line, continuous across the wrap.
- With JTFRAME_SYNC_GEN_INTERLACE_EN: field alternates; odd frame length is 105200 enables; odd-field VS rises at pixel 136.

Source files
------------

// File: rtl/jtframe_sync_gen.sv
// Programmable video timing generator: h/v counters, blanking and offset-shifted sync.
// Define JTFRAME_SYNC_GEN_INTERLACE_EN to add an alternating odd field one line longer.
module jtframe_sync_gen #(
    parameter int unsigned HCNTW    = 10,
    parameter int unsigned VCNTW    = 9,
    parameter int unsigned H_TOTAL  = 400,
    parameter int unsigned HB_START = 320,
    parameter int unsigned HS_START = 336,
    parameter int unsigned HS_END   = 368,
    parameter int unsigned V_TOTAL  = 262,
    parameter int unsigned VB_START = 224,
    parameter int unsigned VS_START = 234,
    parameter int unsigned VS_END   = 237
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pxl_cen,
    input  logic [3:0]       hoffset,
    input  logic [3:0]       voffset,
    output logic [HCNTW-1:0] hcnt,
    output logic [VCNTW-1:0] vcnt,
    output logic             LHBL,
    output logic             LVBL,
    output logic             HS,
    output logic             VS,
    output logic             field
);

    localparam logic [HCNTW-1:0]        HLAST = HCNTW'(H_TOTAL - 1);
    localparam logic [VCNTW-1:0]        VLAST = VCNTW'(V_TOTAL - 1);
    localparam logic signed [HCNTW+1:0] HT_S  = (HCNTW+2)'(H_TOTAL);
    localparam logic signed [VCNTW+1:0] VT_S  = (VCNTW+2)'(V_TOTAL);

    // Offset is smaller than the total, so one correction brings the sum into range.
    function automatic logic [HCNTW-1:0] hmod(input int unsigned base, input logic [3:0] off);
        logic signed [HCNTW+1:0] s;
        s = $signed((HCNTW+2)'(base)) + (HCNTW+2)'($signed(off));
        if (s < 0) s = s + HT_S;
        else if (s >= HT_S) s = s - HT_S;
        return s[HCNTW-1:0];
    endfunction

    function automatic logic [VCNTW-1:0] vmod(input int unsigned base, input logic [3:0] off);
        logic signed [VCNTW+1:0] s;
        s = $signed((VCNTW+2)'(base)) + (VCNTW+2)'($signed(off));
        if (s < 0) s = s + VT_S;
        else if (s >= VT_S) s = s - VT_S;
        return s[VCNTW-1:0];
    endfunction

    logic [HCNTW-1:0] r_hcnt, w_hnext, w_hs_s, w_hs_e, w_vs_px;
    logic [VCNTW-1:0] r_vcnt, w_vnext, w_vs_s, w_vs_e, w_last;
    logic [3:0]       r_hoff, r_voff, w_hoff, w_voff;
    logic             r_lhbl, r_lvbl, r_hs, r_vs, r_field;
    logic             w_hwrap, w_fwrap, w_field_next, w_hs_d, w_vs_d;
`ifdef JTFRAME_SYNC_GEN_INTERLACE_EN
    logic [HCNTW:0]   w_half;
`endif

    always_comb begin
        w_hwrap = (r_hcnt == HLAST);
`ifdef JTFRAME_SYNC_GEN_INTERLACE_EN
        w_last       = r_field ? VCNTW'(V_TOTAL) : VLAST;
        w_fwrap      = w_hwrap && (r_vcnt == w_last);
        w_field_next = w_fwrap ? ~r_field : r_field;
`else
        w_last       = VLAST;
        w_fwrap      = w_hwrap && (r_vcnt == w_last);
        w_field_next = 1'b0;
`endif
        w_hnext = w_hwrap ? '0 : r_hcnt + 1'b1;
        w_vnext = w_fwrap ? '0 : (w_hwrap ? r_vcnt + 1'b1 : r_vcnt);
        // New offsets already apply to pixel (0,0) of the frame that samples them.
        w_hoff  = w_fwrap ? hoffset : r_hoff;
        w_voff  = w_fwrap ? voffset : r_voff;
        w_hs_s  = hmod(HS_START, w_hoff);
        w_hs_e  = hmod(HS_END, w_hoff);
        w_vs_s  = vmod(VS_START, w_voff);
        w_vs_e  = vmod(VS_END, w_voff);
`ifdef JTFRAME_SYNC_GEN_INTERLACE_EN
        w_half = {1'b0, w_hs_s} + (HCNTW+1)'(H_TOTAL / 2);
        if (w_half >= (HCNTW+1)'(H_TOTAL)) w_half = w_half - (HCNTW+1)'(H_TOTAL);
        w_vs_px = w_field_next ? w_half[HCNTW-1:0] : w_hs_s;
`else
        w_vs_px = w_hs_s;
`endif
        // Clear wins over set so an empty window keeps the output low.
        w_hs_d = r_hs;
        if (w_hnext == w_hs_e)      w_hs_d = 1'b0;
        else if (w_hnext == w_hs_s) w_hs_d = 1'b1;
        w_vs_d = r_vs;
        if (w_hnext == w_vs_px) begin
            if (w_vnext == w_vs_e)      w_vs_d = 1'b0;
            else if (w_vnext == w_vs_s) w_vs_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt  <= '0;
            r_vcnt  <= '0;
            r_hoff  <= '0;
            r_voff  <= '0;
            r_lhbl  <= 1'b1;
            r_lvbl  <= 1'b1;
            r_hs    <= 1'b0;
            r_vs    <= 1'b0;
            r_field <= 1'b0;
        end else if (pxl_cen) begin
            r_hcnt  <= w_hnext;
            r_vcnt  <= w_vnext;
            r_hoff  <= w_hoff;
            r_voff  <= w_voff;
            r_lhbl  <= (w_hnext < HCNTW'(HB_START));
            r_lvbl  <= (w_vnext < VCNTW'(VB_START));
            r_hs    <= w_hs_d;
            r_vs    <= w_vs_d;
            r_field <= w_field_next;
        end
    end

    assign hcnt  = r_hcnt;
    assign vcnt  = r_vcnt;
    assign LHBL  = r_lhbl;
    assign LVBL  = r_lvbl;
    assign HS    = r_hs;
    assign VS    = r_vs;
    assign field = r_field;

endmodule

// File: tb/tb_jtframe_sync_gen.sv
// Bench for jtframe_sync_gen: small raster, random enables/offsets, pixel-position reference model.
module tb_jtframe_sync_gen;

    localparam int HCNTW = 6, VCNTW = 5;
    localparam int HT = 40, HB = 32, HSS = 36, HSE = 2;
    localparam int VT = 20, VB = 16, VSS = 17, VSE = 19;
    localparam int FRAME = HT * (VT + 1);
`ifdef JTFRAME_SYNC_GEN_INTERLACE_EN
    localparam bit ILACE = 1'b1;
`else
    localparam bit ILACE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, pxl_cen;
    logic [3:0] hoffset, voffset;
    logic [HCNTW-1:0] hcnt;
    logic [VCNTW-1:0] vcnt;
    logic LHBL, LVBL, HS, VS, field;

    jtframe_sync_gen #(
        .HCNTW(HCNTW), .VCNTW(VCNTW), .H_TOTAL(HT), .HB_START(HB),
        .HS_START(HSS), .HS_END(HSE), .V_TOTAL(VT), .VB_START(VB),
        .VS_START(VSS), .VS_END(VSE)
    ) u_dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .hoffset(hoffset), .voffset(voffset),
        .hcnt(hcnt), .vcnt(vcnt), .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS), .field(field)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference: raster position, offsets in effect, sync levels after their last edge.
    int  m_h, m_v, m_ho, m_vo, m_field;
    bit  m_hs, m_vs;

    function automatic int smod(input int a, input int m);
        return ((a % m) + m) % m;
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_ho = 0; m_vo = 0; m_field = 0; m_hs = 0; m_vs = 0;
    endtask

    task automatic model_step(input bit pen, input logic [3:0] ho, input logic [3:0] vo);
        int last, hs_s, hs_e, vs_s, vs_e, vpx;
        if (!pen) return;
        last = (ILACE && m_field == 1) ? VT : VT - 1;
        m_h++;
        if (m_h == HT) begin
            m_h = 0;
            if (m_v == last) begin
                m_v = 0;
                if (ILACE) m_field ^= 1;
            end else begin
                m_v++;
            end
        end
        if (m_h == 0 && m_v == 0) begin
            m_ho = int'($signed(ho));
            m_vo = int'($signed(vo));
        end
        hs_s = smod(HSS + m_ho, HT);
        hs_e = smod(HSE + m_ho, HT);
        vs_s = smod(VSS + m_vo, VT);
        vs_e = smod(VSE + m_vo, VT);
        vpx  = (m_field == 1) ? smod(hs_s + HT / 2, HT) : hs_s;
        if (m_h == hs_e) m_hs = 0;
        else if (m_h == hs_s) m_hs = 1;
        if (m_h == vpx) begin
            if (m_v == vs_e) m_vs = 0;
            else if (m_v == vs_s) m_vs = 1;
        end
    endtask

    task automatic check_all();
        check("hcnt", 32'(hcnt), 32'(m_h));
        check("vcnt", 32'(vcnt), 32'(m_v));
        check("LHBL", 32'(LHBL), 32'(m_h < HB));
        check("LVBL", 32'(LVBL), 32'(m_v < VB));
        check("HS", 32'(HS), 32'(m_hs));
        check("VS", 32'(VS), 32'(m_vs));
        check("field", 32'(field), 32'(m_field));
    endtask

    // cen_mode: 0 always enabled, 1 roughly one enable in four; off_rate 0 keeps offsets.
    task automatic run(input int n, input int cen_mode, input int off_rate);
        for (int i = 0; i < n; i++) begin
            pxl_cen = (cen_mode == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
            if (off_rate != 0 && $urandom_range(0, off_rate - 1) == 0) begin
                hoffset = 4'($urandom);
                voffset = 4'($urandom);
            end
            @(posedge clk);
            model_step(pxl_cen, hoffset, voffset);
            #1;
            check_all();
        end
    endtask

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; hoffset = 4'd0; voffset = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        run(HT + 1, 0, 0);
        run(2 * FRAME, 0, 0);
        // Extreme offsets applied mid-frame only take effect at the next frame start.
        run(FRAME / 2, 0, 0);
        hoffset = 4'b1000;
        voffset = 4'd7;
        run(2 * FRAME, 0, 0);
        run(3 * FRAME, 0, 30);
        run(1500, 1, 30);
        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        run(2 * FRAME, 0, 20);
        run(800, 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
